// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, parity modes and receiver state encoding.
package uart_pkg;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_FRAME_BITS     = 11;
  localparam int UART_OVERSAMPLE_DEF = 16;

  localparam bit UART_PAR_EVEN = 1'b0;
  localparam bit UART_PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Parallel side of the UART receiver: received byte, frame strobe and status.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] p_data_out;
  logic                      data_valid;
  logic                      parity_err;
  logic                      frame_err;
  logic                      rx_busy;

  modport master (
    output p_data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    output rx_busy
  );

  modport slave (
    input p_data_out,
    input data_valid,
    input parity_err,
    input frame_err,
    input rx_busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
module sync_2ff #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, 8 data LSB first, parity, stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter bit PARITY_ODD = UART_PAR_EVEN
) (
  input  logic      reg_clk,
  input  logic      reg_rst,
  input  logic      serial_in,
  uart_rx_if.master rx
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_IDX = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] sh_q, sh_d;
  logic perr_q, perr_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic par_err_q, par_err_d;
  logic frm_err_q, frm_err_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (reg_clk),
    .rst (reg_rst),
    .d   (serial_in),
    .q   (rx_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    perr_d    = perr_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is high again at mid-bit was only a glitch
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[UART_DATA_BITS-1:1]};
          if (idx_q == LAST_IDX) state_d = RX_PARITY;
          else idx_d = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          perr_d  = rx_s ^ (^sh_q) ^ PARITY_ODD;
          state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          data_d    = sh_q;
          par_err_d = perr_q;
          frm_err_d = ~rx_s;
          valid_d   = 1'b1;
          state_d   = rx_s ? RX_IDLE : RX_WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        // A held-low (break) line must not look like a new start bit
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      perr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      perr_q    <= perr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign rx.p_data_out = data_q;
  assign rx.data_valid = valid_q;
  assign rx.parity_err = par_err_q;
  assign rx.frame_err  = frm_err_q;
  assign rx.rx_busy    = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: even and odd parity receivers share one serial line.
module tb_uart_rx;

  localparam int OS = 16;

  logic reg_clk = 1'b0;
  logic reg_rst = 1'b1;
  logic serial_in = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  uart_rx_if rx_e();
  uart_rx_if rx_o();

  uart_rx #(.OVERSAMPLE(OS), .PARITY_ODD(1'b0)) dut (
    .reg_clk   (reg_clk),
    .reg_rst   (reg_rst),
    .serial_in (serial_in),
    .rx        (rx_e)
  );

  uart_rx #(.OVERSAMPLE(OS), .PARITY_ODD(1'b1)) dut_odd (
    .reg_clk   (reg_clk),
    .reg_rst   (reg_rst),
    .serial_in (serial_in),
    .rx        (rx_o)
  );

  always #5 reg_clk = ~reg_clk;
  always @(posedge reg_clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [7:0] d;
    logic       pe;
    logic       peo;
    logic       fe;
    logic       vo;
  } obs_t;

  obs_t obs_q[$];

  always @(negedge reg_clk) begin
    if (rx_e.data_valid === 1'b1 || rx_o.data_valid === 1'b1)
      obs_q.push_back('{cyc, rx_e.p_data_out, rx_e.parity_err,
                        rx_o.parity_err, rx_e.frame_err,
                        rx_o.data_valid});
  end

  typedef struct {
    logic [7:0] d;
    bit         pb;
    bit         sb;
    bit         e_pe;
    bit         e_peo;
    bit         e_fe;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives a whole frame starting at the current negedge
  task automatic send_frame(input logic [7:0] d, input bit pb,
                            input bit sb, output int tdrv);
    logic [10:0] bits;
    bits = {sb, pb, d, 1'b0};
    tdrv = cyc;
    for (int i = 0; i < 11; i++) begin
      serial_in = bits[i];
      repeat (OS) @(negedge reg_clk);
    end
  endtask

  task automatic idle_bits(input int n);
    serial_in = 1'b1;
    repeat (n * OS) @(negedge reg_clk);
  endtask

  task automatic check_frame(input string nm, input int tdrv,
                             input logic [7:0] d, input bit pe,
                             input bit peo, input bit fe,
                             output int tobs);
    obs_t o;
    tobs = -1;
    chk({nm, " dv count"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      tobs = o.t;
      chk({nm, " dv time"}, o.t, tdrv + 1 + 170);
      chk({nm, " data"}, o.d, d);
      chk({nm, " parity_err"}, o.pe, pe);
      chk({nm, " parity_err odd"}, o.peo, peo);
      chk({nm, " frame_err"}, o.fe, fe);
      chk({nm, " odd dv"}, o.vo, 1);
    end
    obs_q.delete();
  endtask

  function automatic bit model_perr(input logic [7:0] d, input bit pb,
                                    input bit odd);
    bit want;
    want = ($countones(d) % 2 == 1) ^ odd;
    return pb != want;
  endfunction

  task automatic check_idle_outputs(input string nm);
    chk({nm, " p_data_out"}, rx_e.p_data_out, 0);
    chk({nm, " data_valid"}, rx_e.data_valid, 0);
    chk({nm, " parity_err"}, rx_e.parity_err, 0);
    chk({nm, " frame_err"}, rx_e.frame_err, 0);
    chk({nm, " rx_busy"}, rx_e.rx_busy, 0);
  endtask

  initial begin
    int t1, t2, o1, o2, lowcnt;
    logic [7:0] rd;
    bit rpb, rsb;
    int gap;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    reg_rst = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(negedge reg_clk);
    check_idle_outputs("reset");
    reg_rst = 1'b0;
    repeat (5) @(negedge reg_clk);
    obs_q.delete();

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].d, vecs[i].pb, vecs[i].sb, t1);
      check_frame($sformatf("vec%0d", i), t1, vecs[i].d, vecs[i].e_pe,
                  vecs[i].e_peo, vecs[i].e_fe, o1);
      idle_bits(2);
    end

    send_frame(8'h55, 1'b0, 1'b1, t1);
    check_frame("b2b first", t1, 8'h55, 1'b0, 1'b1, 1'b0, o1);
    send_frame(8'hAA, 1'b0, 1'b1, t2);
    check_frame("b2b second", t2, 8'hAA, 1'b0, 1'b1, 1'b0, o2);
    chk("b2b spacing", o2 - o1, 176);
    idle_bits(1);

    send_frame(8'h3C, 1'b0, 1'b0, t1);
    lowcnt = 0;
    for (int i = 0; i < 40 * OS; i++) begin
      @(negedge reg_clk);
      if (rx_e.rx_busy !== 1'b1) lowcnt++;
    end
    check_frame("break", t1, 8'h3C, 1'b0, 1'b1, 1'b1, o1);
    chk("break busy held", lowcnt, 0);
    idle_bits(2);
    chk("break no extra dv", obs_q.size(), 0);
    send_frame(8'h42, 1'b0, 1'b1, t1);
    check_frame("after break", t1, 8'h42, 1'b0, 1'b1, 1'b0, o1);
    idle_bits(1);

    serial_in = 1'b0;
    repeat (4) @(negedge reg_clk);
    serial_in = 1'b1;
    chk("glitch busy seen", rx_e.rx_busy, 1);
    repeat (OS / 2 + 3) @(negedge reg_clk);
    chk("glitch busy cleared", rx_e.rx_busy, 0);
    chk("glitch no dv", obs_q.size(), 0);
    idle_bits(1);

    chk("pre-reset data held", rx_e.p_data_out, 8'h42);
    serial_in = 1'b0;
    repeat (OS) @(negedge reg_clk);
    serial_in = 1'b1;
    repeat (3 * OS) @(negedge reg_clk);
    chk("mid busy", rx_e.rx_busy, 1);
    #2 reg_rst = 1'b1;
    #1;
    check_idle_outputs("async reset");
    @(negedge reg_clk);
    repeat (4) @(negedge reg_clk);
    reg_rst = 1'b0;
    repeat (8) @(negedge reg_clk);
    chk("reset no dv", obs_q.size(), 0);
    send_frame(8'h7E, 1'b0, 1'b1, t1);
    check_frame("post reset", t1, 8'h7E, 1'b0, 1'b1, 1'b0, o1);
    idle_bits(1);

    for (int n = 0; n < 25; n++) begin
      rd  = 8'($urandom);
      rpb = (($countones(rd) % 2) == 1);
      if ($urandom_range(0, 3) == 0) rpb = ~rpb;
      rsb = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 2);
      if (!rsb && gap == 0) gap = 1;
      send_frame(rd, rpb, rsb, t1);
      check_frame($sformatf("rand%0d", n), t1, rd,
                  model_perr(rd, rpb, 1'b0), model_perr(rd, rpb, 1'b1),
                  !rsb, o1);
      if (gap > 0) idle_bits(gap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
